// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: state encoding, opcode and
// extension constants, branch condition codes, flag bit positions and mux selects.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    localparam logic [3:0] OP_REG_ALU = 4'b0000;
    localparam logic [3:0] OP_MEMJ    = 4'b0100;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_LO = 4'b0100;
    localparam logic [3:0] COND_NL = 4'b0101;
    localparam logic [3:0] COND_MI = 4'b0110;
    localparam logic [3:0] COND_PL = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Flag vector is {N,Z,F,L,C} from bit 4 down to bit 0
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [1:0] SEL_ALU_RESULT = 2'b00;
    localparam logic [1:0] SEL_MEM_DATA   = 2'b01;
    localparam logic [1:0] SEL_IMM        = 2'b10;
    localparam logic [1:0] SEL_PC_REL     = 2'b11;

    typedef enum logic [2:0] {
        CLS_REG,
        CLS_IMM,
        CLS_LOAD,
        CLS_STOR,
        CLS_BCOND,
        CLS_JCOND,
        CLS_NOP,
        CLS_HALT
    } ins_class_e;

    typedef struct packed {
        logic       reg_write;
        logic       pc_write;
        logic       pc_increment;
        logic       ir_write;
        logic       mem_req;
        logic       mem_rw;
        logic       sel_mem;
        logic [1:0] sel_alu;
        logic       halted;
    } ctrl_t;

    function automatic ins_class_e classify(input logic [3:0] op, input logic [3:0] ext);
        ins_class_e cls;
        case (op)
            OP_REG_ALU: cls = CLS_REG;
            OP_BCOND:   cls = CLS_BCOND;
            OP_HALT:    cls = CLS_HALT;
            OP_MEMJ: begin
                case (ext)
                    EXT_LOAD:  cls = CLS_LOAD;
                    EXT_STOR:  cls = CLS_STOR;
                    EXT_JCOND: cls = CLS_JCOND;
                    default:   cls = CLS_NOP;
                endcase
            end
            default:    cls = CLS_IMM;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath and
// memory side (slave).
interface cpu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int PSR_W  = 5
);
    logic [DATA_W-1:0] INS;
    logic [PSR_W-1:0]  PSR;
    logic              MemReady;

    logic [3:0]        OpCode;
    logic [3:0]        OpExt;
    logic              RegWrite;
    logic [3:0]        RegIn;
    logic [3:0]        RegA;
    logic [3:0]        RegB;
    logic [DATA_W-1:0] Immediate;
    logic [1:0]        SelALU;
    logic              SelMEM;
    logic              MemRW;
    logic              MemReq;
    logic              PCWrite;
    logic              PCIncrement;
    logic              PCReset;
    logic              IRReset;
    logic              IRWrite;
    logic              PSRReset;
    logic              Halted;
    logic [2:0]        State;

    modport master (
        input  INS, PSR, MemReady,
        output OpCode, OpExt, RegWrite, RegIn, RegA, RegB, Immediate, SelALU,
               SelMEM, MemRW, MemReq, PCWrite, PCIncrement, PCReset, IRReset,
               IRWrite, PSRReset, Halted, State
    );

    modport slave (
        output INS, PSR, MemReady,
        input  OpCode, OpExt, RegWrite, RegIn, RegA, RegB, Immediate, SelALU,
               SelMEM, MemRW, MemReq, PCWrite, PCIncrement, PCReset, IRReset,
               IRWrite, PSRReset, Halted, State
    );

endinterface

// File: rtl/cpu_sequencer_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the flag vector
// to a taken/not-taken decision.
module cond_eval
    import cpu_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags[PSR_Z];
            COND_NE: taken = ~flags[PSR_Z];
            COND_CS: taken = flags[PSR_C];
            COND_CC: taken = ~flags[PSR_C];
            COND_LO: taken = flags[PSR_L];
            COND_NL: taken = ~flags[PSR_L];
            COND_MI: taken = flags[PSR_N];
            COND_PL: taken = ~flags[PSR_N];
            COND_FS: taken = flags[PSR_F];
            COND_FC: taken = ~flags[PSR_F];
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/HALT FSM plus field
// decode, driving datapath strobes and the memory handshake.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PSR_W  = 5
) (
    input logic             Clock,
    input logic             Reset,
    cpu_sequencer_if.master bus
);

    state_e            state_q;
    state_e            state_d;
    ins_class_e        ins_class;
    logic [3:0]        opcode;
    logic [3:0]        opext;
    logic [DATA_W-1:0] imm_ext;
    logic [PSR_W-1:0]  psr_in;
    logic              cond_taken;
    ctrl_t             ctrl;

    assign opcode    = bus.INS[15:12];
    assign opext     = bus.INS[7:4];
    assign ins_class = classify(opcode, opext);
    assign psr_in    = bus.PSR;

    // Memory/jump group carries a register operand, so no immediate is presented
    assign imm_ext = (opcode == OP_MEMJ) ? '0
                   : {{(DATA_W-8){bus.INS[7]}}, bus.INS[7:0]};

    cond_eval u_cond_eval (
        .cond  (bus.INS[11:8]),
        .flags (psr_in[4:0]),
        .taken (cond_taken)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.MemReady) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (ins_class == CLS_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (ins_class == CLS_LOAD || ins_class == CLS_STOR) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (bus.MemReady) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (bus.MemReady) begin
                    ctrl.ir_write     = 1'b1;
                    ctrl.pc_increment = 1'b1;
                end
            end
            ST_EXECUTE: begin
                case (ins_class)
                    CLS_REG: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.sel_alu   = SEL_ALU_RESULT;
                    end
                    CLS_IMM: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.sel_alu   = SEL_IMM;
                    end
                    CLS_BCOND: begin
                        ctrl.pc_write = cond_taken;
                        ctrl.sel_alu  = SEL_PC_REL;
                    end
                    CLS_JCOND: begin
                        ctrl.pc_write = cond_taken;
                        ctrl.sel_alu  = SEL_ALU_RESULT;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.sel_mem = 1'b1;
                ctrl.mem_rw  = (ins_class == CLS_STOR);
                if (bus.MemReady && ins_class == CLS_LOAD) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.sel_alu   = SEL_MEM_DATA;
                end
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset silences every output, including a memory access still in flight
    always_comb begin
        bus.PCReset     = Reset;
        bus.IRReset     = Reset;
        bus.PSRReset    = Reset;
        bus.OpCode      = '0;
        bus.OpExt       = '0;
        bus.RegIn       = '0;
        bus.RegA        = '0;
        bus.RegB        = '0;
        bus.Immediate   = '0;
        bus.RegWrite    = 1'b0;
        bus.SelALU      = '0;
        bus.SelMEM      = 1'b0;
        bus.MemRW       = 1'b0;
        bus.MemReq      = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCIncrement = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.Halted      = 1'b0;
        bus.State       = '0;
        if (!Reset) begin
            bus.OpCode      = opcode;
            bus.OpExt       = opext;
            bus.RegIn       = bus.INS[11:8];
            bus.RegA        = bus.INS[11:8];
            bus.RegB        = bus.INS[3:0];
            bus.Immediate   = imm_ext;
            bus.RegWrite    = ctrl.reg_write;
            bus.SelALU      = ctrl.sel_alu;
            bus.SelMEM      = ctrl.sel_mem;
            bus.MemRW       = ctrl.mem_rw;
            bus.MemReq      = ctrl.mem_req;
            bus.PCWrite     = ctrl.pc_write;
            bus.PCIncrement = ctrl.pc_increment;
            bus.IRWrite     = ctrl.ir_write;
            bus.Halted      = ctrl.halted;
            bus.State       = state_q;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: builds a per-cycle expectation queue for each instruction
// from the instruction-set rules and replays it against the sequencer.
module tb_cpu_sequencer;

    localparam int DATA_W = 16;
    localparam int PSR_W  = 5;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    cpu_sequencer_if #(.DATA_W(DATA_W), .PSR_W(PSR_W)) bus ();

    cpu_sequencer #(.DATA_W(DATA_W), .PSR_W(PSR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  psr;
        logic        mem_ready;
        logic [2:0]  state;
        logic        mem_req;
        logic        ir_write;
        logic        pc_inc;
        logic        reg_write;
        logic        pc_write;
        logic        halted;
        logic        chk_mem;
        logic        sel_mem;
        logic        mem_rw;
        logic        chk_sel_alu;
        logic [1:0]  sel_alu;
        logic        chk_fields;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    // Condition table: pairs (flag, !flag) for Z,C,L,N,F, then 1110 always
    function automatic logic spec_taken(input logic [3:0] c, input logic [4:0] psr);
        logic [4:0] by_pair;
        if (c == 4'd14) return 1'b1;
        if (c > 4'd9) return 1'b0;
        by_pair = {psr[2], psr[4], psr[1], psr[0], psr[3]};
        return by_pair[c[3:1]] ^ c[0];
    endfunction

    function automatic cyc_t blank(input logic [15:0] ins);
        cyc_t r;
        r = '{default: '0};
        r.ins       = ins;
        r.psr       = 5'($urandom);
        r.mem_ready = 1'($urandom);
        return r;
    endfunction

    task automatic plan_instr(input logic [15:0] ins, input logic [4:0] psr,
                              input int fetch_wait, input int mem_wait,
                              input bit abort_mem, input int halt_cycles);
        cyc_t r;
        int op, ext;
        bit is_load, is_stor, is_jc, is_bc, is_reg, is_imm;
        op  = int'(ins[15:12]);
        ext = int'(ins[7:4]);
        is_load = (op == 4) && (ext == 0);
        is_stor = (op == 4) && (ext == 4);
        is_jc   = (op == 4) && (ext == 12);
        is_bc   = (op == 12);
        is_reg  = (op == 0);
        is_imm  = !(op == 0 || op == 4 || op == 12 || op == 15);
        for (int i = 0; i < fetch_wait; i++) begin
            r = blank(ins);
            r.mem_ready = 1'b0; r.state = 3'd0; r.mem_req = 1'b1; r.chk_mem = 1'b1;
            q.push_back(r);
        end
        r = blank(ins);
        r.mem_ready = 1'b1; r.state = 3'd0; r.mem_req = 1'b1; r.chk_mem = 1'b1;
        r.ir_write = 1'b1; r.pc_inc = 1'b1;
        q.push_back(r);
        r = blank(ins);
        r.state = 3'd1; r.chk_fields = 1'b1;
        q.push_back(r);
        if (op == 15) begin
            for (int i = 0; i < halt_cycles; i++) begin
                r = blank(ins);
                r.state = 3'd4; r.halted = 1'b1; r.chk_fields = 1'b1;
                q.push_back(r);
            end
            return;
        end
        r = blank(ins);
        r.psr = psr; r.state = 3'd2; r.chk_fields = 1'b1;
        r.reg_write = is_reg || is_imm;
        r.pc_write  = (is_bc || is_jc) && spec_taken(ins[11:8], psr);
        r.chk_sel_alu = is_reg || is_imm || is_bc || is_jc;
        r.sel_alu = is_imm ? 2'd2 : (is_bc ? 2'd3 : 2'd0);
        q.push_back(r);
        if (is_load || is_stor) begin
            for (int i = 0; i < mem_wait; i++) begin
                r = blank(ins);
                r.mem_ready = 1'b0; r.state = 3'd3; r.mem_req = 1'b1; r.chk_mem = 1'b1;
                r.sel_mem = 1'b1; r.mem_rw = is_stor; r.chk_fields = 1'b1;
                q.push_back(r);
            end
            if (!abort_mem) begin
                r = blank(ins);
                r.mem_ready = 1'b1; r.state = 3'd3; r.mem_req = 1'b1; r.chk_mem = 1'b1;
                r.sel_mem = 1'b1; r.mem_rw = is_stor; r.reg_write = is_load;
                r.chk_sel_alu = is_load; r.sel_alu = 2'd1;
                q.push_back(r);
            end
        end
    endtask

    task automatic run_queue();
        cyc_t r;
        logic [15:0] imm;
        while (q.size() > 0) begin
            r = q.pop_front();
            bus.INS      = r.ins;
            bus.PSR      = r.psr;
            bus.MemReady = r.mem_ready;
            @(negedge Clock);
            step++;
            $display("step %0d ins=%04h state=%0d memreq=%0b irw=%0b regw=%0b pcw=%0b",
                     step, r.ins, bus.State, bus.MemReq, bus.IRWrite, bus.RegWrite, bus.PCWrite);
            check("state", 64'(bus.State), 64'(r.state));
            check("strobes",
                  64'({bus.MemReq, bus.IRWrite, bus.PCIncrement, bus.RegWrite, bus.PCWrite,
                       bus.Halted, bus.PCReset, bus.IRReset, bus.PSRReset}),
                  64'({r.mem_req, r.ir_write, r.pc_inc, r.reg_write, r.pc_write,
                       r.halted, 3'b000}));
            if (r.chk_mem)
                check("mem_sel", 64'({bus.SelMEM, bus.MemRW}), 64'({r.sel_mem, r.mem_rw}));
            if (r.chk_sel_alu)
                check("sel_alu", 64'(bus.SelALU), 64'(r.sel_alu));
            if (r.chk_fields) begin
                imm = (r.ins[15:12] == 4'd4) ? 16'd0
                    : 16'((int'(r.ins[7:0]) ^ 128) - 128);
                check("fields",
                      64'({bus.OpCode, bus.OpExt, bus.RegIn, bus.RegA, bus.RegB}),
                      64'({r.ins[15:12], r.ins[7:4], r.ins[11:8], r.ins[11:8], r.ins[3:0]}));
                check("immediate", 64'(bus.Immediate), 64'(imm));
            end
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.MemReady = 1'($urandom);
            bus.INS      = 16'($urandom) | 16'h8081;
            bus.PSR      = 5'($urandom);
            @(negedge Clock);
            step++;
            $display("step %0d reset pcr=%0b irr=%0b psrr=%0b memreq=%0b",
                     step, bus.PCReset, bus.IRReset, bus.PSRReset, bus.MemReq);
            check("rst_ctl", 64'({bus.PCReset, bus.IRReset, bus.PSRReset}), 64'(3'b111));
            check("rst_zero",
                  64'({bus.State, bus.MemReq, bus.MemRW, bus.SelMEM, bus.IRWrite,
                       bus.PCIncrement, bus.RegWrite, bus.PCWrite, bus.Halted, bus.SelALU}),
                  64'(0));
            check("rst_fields",
                  64'({bus.OpCode, bus.OpExt, bus.RegIn, bus.RegA, bus.RegB, bus.Immediate}),
                  64'(0));
            @(posedge Clock);
            #1;
        end
        Reset = 1'b0;
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        Reset        = 1'b1;
        bus.INS      = '0;
        bus.PSR      = '0;
        bus.MemReady = 1'b0;
        @(posedge Clock);
        #1;
        do_reset(2);

        // Register ALU, immediate ALU, LOAD with a slow memory
        plan_instr(16'h0152, 5'd0, 0, 0, 1'b0, 0);
        plan_instr(16'h51FF, 5'd0, 0, 0, 1'b0, 0);
        plan_instr(16'h4203, 5'd0, 1, 4, 1'b0, 0);
        run_queue();

        // Bcond on Z, then always-taken, then a Jcond on !C
        plan_instr(16'hC005, 5'b01000, 0, 0, 1'b0, 0);
        plan_instr(16'hC005, 5'b10111, 0, 0, 1'b0, 0);
        plan_instr(16'hCE05, 5'b00000, 0, 0, 1'b0, 0);
        plan_instr(16'h43C7, 5'b00001, 2, 0, 1'b0, 0);
        plan_instr(16'h43C7, 5'b00000, 0, 0, 1'b0, 0);
        plan_instr(16'h4A93, 5'b11111, 0, 0, 1'b0, 0);
        run_queue();

        // STOR interrupted by reset while the memory access is pending
        plan_instr(16'h4443, 5'd0, 0, 2, 1'b1, 0);
        run_queue();
        do_reset(2);
        plan_instr(16'h4443, 5'd0, 0, 1, 1'b0, 0);
        run_queue();

        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            op  = 4'($urandom_range(0, 14));
            ins[15:12] = op;
            if (op == 4'd4) begin
                case ($urandom_range(0, 3))
                    0: ins[7:4] = 4'd0;
                    1: ins[7:4] = 4'd4;
                    2: ins[7:4] = 4'd12;
                    default: ins[7:4] = 4'($urandom);
                endcase
            end
            plan_instr(ins, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 0);
        end
        run_queue();

        // HALT holds regardless of MemReady until reset, then normal fetch resumes
        plan_instr(16'hF000, 5'd0, 0, 0, 1'b0, 10);
        run_queue();
        do_reset(1);
        plan_instr(16'h0152, 5'd0, 0, 0, 1'b0, 0);
        run_queue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
